// File: rtl/memory_reg_ctrl.sv
// ============================================================================
// Module   : memory_reg_ctrl
// Brief    : Execute->Memory pipeline register with data-memory handshake,
//            stall generation and optional access timeout (MEMCTRL_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_reg_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_RegWriteE,
    input  logic [1:0] i_ResultSrcE,
    input  logic       i_MemWriteE,
    input  logic [4:0] i_RdE,
    input  logic       i_FlushM,
    input  logic       i_MemAck,
    output logic       o_MemReq,
    output logic       o_MemWe,
    output logic       o_StallM,
    output logic       o_RegWriteM,
    output logic [1:0] o_ResultSrcM,
    output logic [4:0] o_RdM,
    output logic       o_MemErr
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACCESS = 1'b1;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("memory_reg_ctrl: TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    logic [0:0] r_state;
    logic       r_reg_write;
    logic [1:0] r_result_src;
    logic       r_mem_write;
    logic [4:0] r_rd;

    logic       w_access;
    logic       w_ack;
    logic       w_stall;
    logic       w_timeout;
    logic       w_n_reg_write;
    logic [1:0] w_n_result_src;
    logic       w_n_mem_write;
    logic [4:0] w_n_rd;
    logic       w_n_mem_op;

    assign w_access = (r_state == c_ACCESS);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    // The last permitted wait cycle behaves as a forced ack.
    assign w_timeout = w_access & ~i_MemAck & (r_wait_cnt == c_TO_LAST);

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if (w_stall) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    assign o_MemErr = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign o_MemErr  = 1'b0;
`endif

    assign w_ack   = i_MemAck | w_timeout;
    assign w_stall = w_access & ~w_ack;

    always_comb begin
        w_n_reg_write  = i_RegWriteE;
        w_n_result_src = i_ResultSrcE;
        w_n_mem_write  = i_MemWriteE;
        w_n_rd         = i_RdE;
        if (i_FlushM) begin
            w_n_reg_write  = 1'b0;
            w_n_result_src = 2'b00;
            w_n_mem_write  = 1'b0;
            w_n_rd         = 5'd0;
        end
    end

    assign w_n_mem_op = (w_n_result_src == 2'b01) | w_n_mem_write;

    // Whenever the stage advances, the FSM simply follows the newly loaded op.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_state      <= c_IDLE;
            r_reg_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_mem_write  <= 1'b0;
            r_rd         <= 5'd0;
        end else if (!w_stall) begin
            r_state      <= w_n_mem_op ? c_ACCESS : c_IDLE;
            r_reg_write  <= w_n_reg_write;
            r_result_src <= w_n_result_src;
            r_mem_write  <= w_n_mem_write;
            r_rd         <= w_n_rd;
        end
    end

    assign o_MemReq     = w_access;
    assign o_MemWe      = w_access & r_mem_write;
    assign o_StallM     = w_stall;
    assign o_RegWriteM  = r_reg_write & ~w_stall & ~w_timeout;
    assign o_ResultSrcM = r_result_src;
    assign o_RdM        = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_memory_reg_ctrl.sv
// ============================================================================
// Module   : tb_memory_reg_ctrl
// Brief    : Directed, table-driven self-checking bench for memory_reg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reg_write_e;
    logic [1:0] result_src_e;
    logic       mem_write_e;
    logic [4:0] rd_e;
    logic       flush_m;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       stall_m;
    logic       reg_write_m;
    logic [1:0] result_src_m;
    logic [4:0] rd_m;
    logic       mem_err;

    int errors = 0;
    int checks = 0;

    memory_reg_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst_n),
        .i_RegWriteE (reg_write_e),
        .i_ResultSrcE(result_src_e),
        .i_MemWriteE (mem_write_e),
        .i_RdE       (rd_e),
        .i_FlushM    (flush_m),
        .i_MemAck    (mem_ack),
        .o_MemReq    (mem_req),
        .o_MemWe     (mem_we),
        .o_StallM    (stall_m),
        .o_RegWriteM (reg_write_m),
        .o_ResultSrcM(result_src_m),
        .o_RdM       (rd_m),
        .o_MemErr    (mem_err)
    );

    always #5 clk = ~clk;

    // Expected-output packing: {req, we, stall, regwm, src[1:0], rd[4:0], err}
    typedef struct packed {
        logic       rst_n;
        logic       regw;
        logic [1:0] src;
        logic       memw;
        logic [4:0] rd;
        logic       flush;
        logic       ack;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] ex(input logic req, input logic we, input logic st,
                                       input logic rw, input logic [1:0] src,
                                       input logic [4:0] rd, input logic err);
        return {req, we, st, rw, src, rd, err};
    endfunction

    function automatic vec_t mk(input logic r, input logic rw, input logic [1:0] src,
                                input logic mw, input logic [4:0] rd, input logic fl,
                                input logic ak, input logic [11:0] e);
        vec_t v;
        v.rst_n = r; v.regw = rw; v.src = src; v.memw = mw;
        v.rd = rd; v.flush = fl; v.ack = ak; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {mem_req, mem_we, stall_m, reg_write_m, result_src_m, rd_m, mem_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/we/stall/rw/src/rd/err=%b required=%b", name, act, exp);
        end
    endtask

    initial begin
        logic [11:0] z;
        z = 12'd0;

        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd5,  0, 0, z));                          // ALU rd5
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(0,0,0,1,2'b00,5'd5,0)));
        vecs.push_back(mk(1, 1, 2'b01, 0, 5'd7,  0, 0, z));                          // load rd7
        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd3,  0, 0, ex(1,0,1,0,2'b01,5'd7,0)));
        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd3,  0, 0, ex(1,0,1,0,2'b01,5'd7,0)));
        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd3,  0, 1, ex(1,0,0,1,2'b01,5'd7,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(0,0,0,1,2'b00,5'd3,0)));
        vecs.push_back(mk(1, 0, 2'b00, 1, 5'd2,  0, 0, z));                          // store
        vecs.push_back(mk(1, 1, 2'b01, 0, 5'd8,  0, 1, ex(1,1,0,0,2'b00,5'd2,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 1, ex(1,0,0,1,2'b01,5'd8,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, z));
        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd9,  1, 0, z));                          // flushed ALU
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, z));
        vecs.push_back(mk(1, 1, 2'b01, 0, 5'd10, 0, 0, z));                          // load rd10
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  1, 0, ex(1,0,1,0,2'b01,5'd10,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 1, ex(1,0,0,1,2'b01,5'd10,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, z));
        vecs.push_back(mk(1, 1, 2'b00, 0, 5'd4,  0, 1, z));                          // ack while idle
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 1, ex(0,0,0,1,2'b00,5'd4,0)));
        vecs.push_back(mk(1, 1, 2'b01, 0, 5'd11, 0, 0, z));                          // load, then reset
        vecs.push_back(mk(0, 0, 2'b00, 0, 5'd0,  0, 0, ex(1,0,1,0,2'b01,5'd11,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, z));
`ifdef MEMCTRL_TIMEOUT_EN
        vecs.push_back(mk(1, 1, 2'b01, 0, 5'd13, 0, 0, z));                          // load, no ack
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(1,0,1,0,2'b01,5'd13,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(1,0,1,0,2'b01,5'd13,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(1,0,1,0,2'b01,5'd13,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(1,0,0,0,2'b01,5'd13,0)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, ex(0,0,0,0,2'b00,5'd0,1)));
        vecs.push_back(mk(1, 0, 2'b00, 0, 5'd0,  0, 0, z));
`endif

        // Reset held for two edges with every input driven high.
        rst_n = 1'b0; reg_write_e = 1'b1; result_src_e = 2'b11; mem_write_e = 1'b1;
        rd_e = 5'd31; flush_m = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_edge1", z);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_edge2", z);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n        = vecs[i].rst_n;
            reg_write_e  = vecs[i].regw;
            result_src_e = vecs[i].src;
            mem_write_e  = vecs[i].memw;
            rd_e         = vecs[i].rd;
            flush_m      = vecs[i].flush;
            mem_ack      = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_reg_ctrl.md
MEMORY_REG_CTRL -- requirements
Module: memory_reg_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 16, meaning the max wait cycles for a memory ack (range 2..255; used only under MEMCTRL_TIMEOUT_EN).
REQ-002 SHALL provide port i_Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port i_Reset  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port i_RegWriteE  input  1  register-write enable from Execute.
REQ-005 SHALL provide port i_ResultSrcE  input  2  result select from Execute (2'b01 = load).
REQ-006 SHALL provide port i_MemWriteE  input  1  store enable from Execute.
REQ-007 SHALL provide port i_RdE  input  5  destination register from Execute.
REQ-008 SHALL provide port i_FlushM  input  1  replace the incoming Execute op with a bubble.
REQ-009 SHALL provide port i_MemAck  input  1  data memory completes the current access this cycle.
REQ-010 SHALL provide port o_MemReq  output  1  data memory access request.
REQ-011 SHALL provide port o_MemWe  output  1  request is a store.
REQ-012 SHALL provide port o_StallM  output  1  stall Fetch/Decode/Execute; hold this stage.
REQ-013 SHALL provide port o_RegWriteM  output  2-bit-free 1  register-write enable to the Writeback register, gated.
REQ-014 SHALL provide port o_ResultSrcM  output  2  result select to the Writeback register.
REQ-015 SHALL provide port o_RdM  output  5  held destination register, for the hazard unit.
REQ-016 SHALL provide port o_MemErr  output  1  one-cycle pulse when an access times out.

Function
REQ-017 SHALL hold one stage register R = {RegWrite, ResultSrc, MemWrite, Rd}; "mem op" means R.ResultSrc==2'b01 or R.MemWrite==1.
REQ-018 SHALL load R from the E inputs on every edge where o_StallM==0; R SHALL hold when o_StallM==1.
REQ-019 SHALL load all-zero R (bubble) instead of the E inputs when i_FlushM==1 and o_StallM==0; i_FlushM SHALL be ignored while o_StallM==1.
REQ-020 SHALL implement FSM states IDLE and ACCESS.
REQ-021 FSM transitions: IDLE->ACCESS when R loads a mem op; ACCESS->ACCESS while i_MemAck==0; on i_MemAck==1 -> ACCESS if the newly loaded op is a mem op, else IDLE.
REQ-022 SHALL drive o_MemReq = (state==ACCESS) and o_MemWe = (state==ACCESS) & R.MemWrite.
REQ-023 SHALL drive o_StallM = (state==ACCESS) & ~i_MemAck, combinationally (zero-cycle ack-to-release).
REQ-024 SHALL drive o_RegWriteM = R.RegWrite & ~o_StallM, so the Writeback register captures a bubble while waiting; o_ResultSrcM = R.ResultSrc and o_RdM = R.Rd, ungated.
REQ-025 Latency: a non-mem op SHALL appear on the M outputs 1 cycle after capture; a mem op SHALL appear with o_RegWriteM valid in the cycle i_MemAck==1.
REQ-026 Back-to-back mem ops with same-cycle ack SHALL issue o_MemReq continuously with no idle cycle.
REQ-027 i_MemAck while IDLE SHALL be ignored.

Reset
REQ-028 When i_Reset==0 at a rising edge, the block SHALL set R=0, state=IDLE, timeout counter=0 and o_MemErr=0, overriding stall, flush and ack.
REQ-029 Reset during ACCESS SHALL abandon the access; o_MemReq SHALL be 0 in the first cycle after the reset edge.

Configuration
REQ-030 With macro MEMCTRL_TIMEOUT_EN defined, the block SHALL count cycles spent in ACCESS without ack, starting at 0 on entry and reset on ack.
REQ-031 With MEMCTRL_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES-1 with no ack, the block SHALL do all of the following:
- treat that cycle as a forced ack: o_StallM=0, o_RegWriteM=0;
- pulse o_MemErr for 1 cycle on the next edge;
- load R per REQ-018 and REQ-021.
REQ-032 Without MEMCTRL_TIMEOUT_EN, the block SHALL wait indefinitely, SHALL tie o_MemErr to 0, and SHALL contain no counter logic.

Verification
REQ-033 Reset: i_Reset=0 for 2 cycles with all inputs driven to 1 -> all outputs 0 and state IDLE after the edge.
REQ-034 ALU op: RegWriteE=1, ResultSrcE=00, RdE=5 -> the next cycle shows o_RegWriteM=1, o_RdM=5, o_MemReq=0, o_StallM=0.
REQ-035 Load, ack after 3 cycles: RdE=7, ResultSrcE=01 -> o_MemReq=1 for 3 cycles; o_StallM=1 for the first 2 cycles; o_RegWriteM=0 for the first 2 cycles and 1 in the ack cycle.
REQ-036 Store then load, each with immediate ack -> o_MemReq high for 2 consecutive cycles; o_MemWe=1 then 0; o_StallM never 1.
REQ-037 Flush: i_FlushM=1 on an ALU op with RdE=9 -> the next cycle shows o_RegWriteM=0 and o_RdM=0; flush asserted during a stalled load -> ignored, and the load completes.
REQ-038 With MEMCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no ack -> o_StallM=1 for 3 cycles, then released with o_RegWriteM=0, and o_MemErr=1 for exactly 1 cycle.
